// File: rtl/macc_fixed32.sv
// Block accumulator for a signed 32-bit fixed-point stream: sums N accepted samples,
// then emits the saturated 32-bit block sum with a one-cycle valid pulse and restarts.
module macc_fixed32 #(
  parameter int LEN_W = 16
) (
  input  logic             macc_clk,
  input  logic             macc_reset,
  input  logic             macc_init,
  input  logic             macc_in_disable,
  input  logic [31:0]      macc_in_fixed_in_32,
  input  logic [LEN_W-1:0] macc_in_len,
  output logic [31:0]      macc_out_fixed_out_32,
  output logic             macc_out_valid,
  output logic             macc_out_sat,
  output logic [LEN_W-1:0] macc_out_count
);

  localparam int ACC_W = 32 + LEN_W;

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, sum;
  logic [LEN_W-1:0]         count_q, count_d, len_q, len_d, len_fresh, len_eff;
  logic [31:0]              out_q, out_d;
  logic                     sat_q, sat_d;
  logic                     reset_i, accept, final_acc, ovf_pos, ovf_neg;

  always_comb begin
    reset_i   = macc_reset | macc_init;
    accept    = !reset_i && !macc_in_disable;
    len_fresh = (macc_in_len == '0) ? LEN_W'(1) : macc_in_len;
    // The first sample of a block uses the freshly latched length, not the stale len_q.
    len_eff   = (count_q == '0) ? len_fresh : len_q;
    sum       = acc_q + {{LEN_W{macc_in_fixed_in_32[31]}}, macc_in_fixed_in_32};
    final_acc = accept && (({1'b0, count_q} + (LEN_W+1)'(1)) == {1'b0, len_eff});
    ovf_pos   = !sum[ACC_W-1] && (|sum[ACC_W-2:31]);
    ovf_neg   =  sum[ACC_W-1] && !(&sum[ACC_W-2:31]);

    state_d = ACCUM;
    acc_d   = acc_q;
    count_d = count_q;
    len_d   = len_q;
    out_d   = out_q;
    sat_d   = sat_q;

    if (reset_i) begin
      acc_d   = '0;
      count_d = '0;
      len_d   = LEN_W'(1);
      out_d   = '0;
      sat_d   = 1'b0;
    end else if (accept) begin
      if (count_q == '0) len_d = len_fresh;
      if (final_acc) begin
        state_d = EMIT;
        acc_d   = '0;
        count_d = '0;
        sat_d   = ovf_pos | ovf_neg;
        if (ovf_pos)      out_d = 32'h7FFF_FFFF;
        else if (ovf_neg) out_d = 32'h8000_0000;
        else              out_d = sum[31:0];
      end else begin
        acc_d   = sum;
        count_d = count_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge macc_clk) begin
    state_q <= state_d;
    acc_q   <= acc_d;
    count_q <= count_d;
    len_q   <= len_d;
    out_q   <= out_d;
    sat_q   <= sat_d;
  end

  assign macc_out_fixed_out_32 = out_q;
  assign macc_out_valid        = (state_q == EMIT);
  assign macc_out_sat          = sat_q;
  assign macc_out_count        = count_q;

endmodule
